program_readback: RTL and testbench
===================================

// Module: program_readback
// PURPOSE
// - Reads the CPU instruction memory back over its read port, one halfword per index, from START_INDEX to END_INDEX inclusive.
// - Undoes the byte reversal applied at download, so out_data matches the assembler listing order.
// - Presents each word on a valid/ready stream for LED, UART or 7-segment display logic.
// - Lets the board-level top check that the downloaded program landed correctly.
// PARAMETERS
// ADDR_W       8   width of instruction index
// DATA_W       16  instruction width; must be even
// START_INDEX  10  first index read
// END_INDEX    22  last index read, inclusive
// PORTS
// clk        in   1       system clock (all logic on posedge)
// rst_n      in   1       synchronous active-low reset
// start      in   1       one-cycle pulse: begin a readback pass
// rd_en      out  1       memory read strobe
// rd_index   out  ADDR_W  memory read address
// rd_data    in   DATA_W  memory data; valid exactly 1 cycle after rd_en
// out_valid  out  1       out_data/out_index valid
// out_ready  in   1       consumer accepts word when out_valid & out_ready
// out_data   out  DATA_W  instruction, bytes swapped back: {rd_data[7:0], rd_data[15:8]}
// out_index  out  ADDR_W  index of out_data
// busy       out  1       pass in progress
// done       out  1       one-cycle pulse at end of pass
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state IDLE; all outputs 0; index register = START_INDEX.
// - Reset mid-pass aborts immediately: no done pulse, no further rd_en.
// - FSM states: IDLE, READ, CAPTURE, PRESENT, FINISH.
// - IDLE: busy=0. On start:
//   - START_INDEX>END_INDEX: go FINISH (zero words).
//   - Otherwise idx<=START_INDEX, go READ.
// - READ: rd_en=1, rd_index=idx for exactly this cycle. Go CAPTURE.
// - CAPTURE: latch byte-swapped rd_data into out_data, idx into out_index. Go PRESENT.
// - PRESENT: out_valid=1; out_data/out_index held stable until handshake.
//   - Handshake with idx==END_INDEX: go FINISH.
//   - Handshake otherwise: idx<=idx+1, go READ.
//   - out_valid drops the cycle after the handshake.
// - FINISH: done=1 for exactly one cycle, busy=0 again. Go IDLE.
// - busy=1 in READ, CAPTURE, PRESENT.
// - start is ignored unless state is IDLE, including the FINISH cycle.
// - Throughput: with out_ready held high, one word per 3 cycles. For N words, done asserts 3N+1 cycles after the start edge.
// - Index arithmetic is ADDR_W-bit. END_INDEX = 2^ADDR_W-1 must terminate on the compare, never wrap to 0.
// - rd_en is never asserted outside READ. At most one outstanding read.
// TESTING
// - Memory model: [10]=16'h2021, [11]=16'h0022, [22]=16'hfee7; out_ready=1; start pulse.
//   -> 13 words, index 10..22.
//   -> Index 10 gives out_data=16'h2120; index 22 gives 16'he7fe.
//   -> done pulses once, 40 cycles after start.
// - Backpressure: out_ready=0 for 5 cycles on index 11 word.
//   -> out_valid=1 with out_data=16'h2200 held stable.
//   -> No rd_en until handshake; next rd_index=12.
// - Start while busy: second start pulse at index 15.
//   -> Ignored; single pass, single done pulse.
// - rst_n=0 for 1 cycle while in PRESENT at index 14.
//   -> Next cycle all outputs 0, no done pulse.
//   -> A later start restarts at index 10.
// - START_INDEX=5, END_INDEX=4: start.
//   -> No rd_en, no out_valid; done=1 on the cycle after start.
// - START_INDEX=254, END_INDEX=255.
//   -> Exactly 2 words (254, 255), then done.
//   -> rd_index never returns to 0.

Source files
------------

// File: rtl/program_readback.sv
// Streams instruction memory words START_INDEX..END_INDEX out on a valid/ready port,
// restoring the byte order that the downloader reversed.
//
// state   | meaning
// IDLE    | waiting for start
// READ    | read strobe issued for idx
// CAPTURE | memory data arrives, latched byte-swapped
// PRESENT | word offered until consumer takes it
// FINISH  | one-cycle done pulse
module program_readback #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned START_INDEX = 10,
  parameter int unsigned END_INDEX   = 22
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_index_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_index_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned HALF_W = DATA_W / 2;
  localparam logic [ADDR_W-1:0] START_IDX = ADDR_W'(START_INDEX);
  localparam logic [ADDR_W-1:0] END_IDX   = ADDR_W'(END_INDEX);
  localparam bit EMPTY_PASS = (START_INDEX > END_INDEX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    PRESENT = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic [DATA_W-1:0] swapped;

  assign swapped = {rd_data_i[HALF_W-1:0], rd_data_i[DATA_W-1:HALF_W]};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    rd_en_o     = 1'b0;
    rd_index_o  = '0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (EMPTY_PASS) begin
            state_d = FINISH;
          end else begin
            idx_d   = START_IDX;
            state_d = READ;
          end
        end
      end

      READ: begin
        rd_en_o    = 1'b1;
        rd_index_o = idx_q;
        busy_o     = 1'b1;
        state_d    = CAPTURE;
      end

      CAPTURE: begin
        busy_o      = 1'b1;
        out_data_d  = swapped;
        out_index_d = idx_q;
        state_d     = PRESENT;
      end

      PRESENT: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          // Compare before incrementing so END_INDEX at the top of the range never wraps.
          if (idx_q == END_IDX) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = READ;
          end
        end
      end

      FINISH: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      idx_q       <= START_IDX;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_index_o = out_index_q;

endmodule

// File: tb/tb_program_readback.sv
// Directed bench for program_readback: normal pass, backpressure, ignored start,
// mid-pass reset, empty range and top-of-range termination.
module tb_program_readback;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        m_start, m_rd_en, m_out_valid, m_out_ready, m_busy, m_done;
  logic [7:0]  m_rd_index, m_out_index;
  logic [15:0] m_rd_data, m_out_data;

  logic        e_start, e_rd_en, e_out_valid, e_out_ready, e_busy, e_done;
  logic [7:0]  e_rd_index, e_out_index;
  logic [15:0] e_rd_data, e_out_data;

  logic        w_start, w_rd_en, w_out_valid, w_out_ready, w_busy, w_done;
  logic [7:0]  w_rd_index, w_out_index;
  logic [15:0] w_rd_data, w_out_data;

  int n_tests = 0;
  int n_fail  = 0;

  program_readback #(.ADDR_W(8), .DATA_W(16), .START_INDEX(10), .END_INDEX(22)) u_main (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(m_start), .rd_en_o(m_rd_en),
    .rd_index_o(m_rd_index), .rd_data_i(m_rd_data), .out_valid_o(m_out_valid),
    .out_ready_i(m_out_ready), .out_data_o(m_out_data), .out_index_o(m_out_index),
    .busy_o(m_busy), .done_o(m_done));

  program_readback #(.ADDR_W(8), .DATA_W(16), .START_INDEX(5), .END_INDEX(4)) u_empty (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(e_start), .rd_en_o(e_rd_en),
    .rd_index_o(e_rd_index), .rd_data_i(e_rd_data), .out_valid_o(e_out_valid),
    .out_ready_i(e_out_ready), .out_data_o(e_out_data), .out_index_o(e_out_index),
    .busy_o(e_busy), .done_o(e_done));

  program_readback #(.ADDR_W(8), .DATA_W(16), .START_INDEX(254), .END_INDEX(255)) u_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(w_start), .rd_en_o(w_rd_en),
    .rd_index_o(w_rd_index), .rd_data_i(w_rd_data), .out_valid_o(w_out_valid),
    .out_ready_i(w_out_ready), .out_data_o(w_out_data), .out_index_o(w_out_index),
    .busy_o(w_busy), .done_o(w_done));

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    case (a)
      8'd10:   mem_word = 16'h2021;
      8'd11:   mem_word = 16'h0022;
      8'd22:   mem_word = 16'hfee7;
      default: mem_word = {a, ~a};
    endcase
  endfunction

  function automatic logic [15:0] swap16(input logic [15:0] d);
    swap16 = {d[7:0], d[15:8]};
  endfunction

  // Synchronous-read memory: data valid one cycle after the strobe.
  always @(posedge clk) begin
    if (m_rd_en) m_rd_data <= mem_word(m_rd_index);
    if (e_rd_en) e_rd_data <= mem_word(e_rd_index);
    if (w_rd_en) w_rd_data <= mem_word(w_rd_index);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain pass; 1: stall on index 11 plus a stray start; 2: reset at index 14
  task automatic run_main(input int mode);
    int cyc = 0;
    int words = 0;
    int dones = 0;
    int stall = 0;
    int quiet = 0;
    logic [7:0] exp_idx = 8'd10;
    bit expect12 = 1'b0;
    bit restarted = 1'b0;
    bit finished = 1'b0;
    m_out_ready = 1'b1;
    m_start = 1'b1;
    while (cyc < 200 && !finished) begin
      step();
      cyc++;
      m_start = 1'b0;
      if (m_done) dones++;
      if (expect12 && m_rd_en) begin
        chk("rd_index_after_stall", m_rd_index, 12);
        expect12 = 1'b0;
      end
      if (m_out_valid) begin
        if (mode == 2 && m_out_index == 8'd14) begin
          rst_n = 1'b0;
          step();
          chk("rst_all_outputs_zero",
              {m_rd_en, m_out_valid, m_busy, m_done, m_rd_index, m_out_data, m_out_index}, 0);
          rst_n = 1'b1;
          for (int i = 0; i < 6; i++) begin
            step();
            if (m_done || m_rd_en || m_busy) quiet++;
          end
          chk("rst_no_done_no_read", quiet, 0);
          chk("rst_done_before_abort", dones, 0);
          return;
        end
        if (mode == 1 && m_out_index == 8'd11 && stall < 5) begin
          m_out_ready = 1'b0;
          stall++;
          chk("stall_data_held", m_out_data, 16'h2200);
          chk("stall_no_rd_en", m_rd_en, 0);
        end else begin
          m_out_ready = 1'b1;
          chk($sformatf("word_index_%0d", exp_idx), m_out_index, exp_idx);
          chk($sformatf("word_data_%0d", exp_idx), m_out_data, swap16(mem_word(exp_idx)));
          if (exp_idx == 8'd10) chk("idx10_data", m_out_data, 16'h2120);
          if (exp_idx == 8'd22) chk("idx22_data", m_out_data, 16'he7fe);
          if (mode == 1 && exp_idx == 8'd11) expect12 = 1'b1;
          words++;
          exp_idx++;
        end
        if (mode == 1 && m_out_index == 8'd15 && !restarted) begin
          m_start = 1'b1;
          restarted = 1'b1;
        end
      end
      if (m_done) begin
        chk("done_cycle", cyc, (mode == 1) ? 45 : 40);
        finished = 1'b1;
      end
    end
    chk("pass_finished", finished, 1);
    chk("word_count", words, 13);
    for (int i = 0; i < 4; i++) begin
      step();
      if (m_done) dones++;
    end
    chk("done_pulses", dones, 1);
    chk("idle_after_pass", {m_busy, m_out_valid, m_rd_en}, 0);
    if (mode == 1) chk("stall_cycles", stall, 5);
  endtask

  initial begin : main
    int bad;
    int words;
    int zero_hits;
    bit seen_done;
    logic [7:0] got0;
    logic [7:0] got1;
    rst_n = 1'b0;
    m_start = 1'b0; e_start = 1'b0; w_start = 1'b0;
    m_out_ready = 1'b1; e_out_ready = 1'b1; w_out_ready = 1'b1;
    repeat (3) step();
    chk("reset_main_outputs",
        {m_rd_en, m_out_valid, m_busy, m_done, m_rd_index, m_out_data, m_out_index}, 0);
    chk("reset_empty_outputs", {e_rd_en, e_out_valid, e_busy, e_done}, 0);
    chk("reset_wrap_outputs", {w_rd_en, w_out_valid, w_busy, w_done}, 0);
    rst_n = 1'b1;
    step();

    run_main(0);
    run_main(1);
    run_main(2);
    run_main(0);

    e_start = 1'b1;
    step();
    e_start = 1'b0;
    chk("empty_done_next_cycle", e_done, 1);
    chk("empty_not_busy", e_busy, 0);
    bad = 0;
    if (e_rd_en || e_out_valid) bad++;
    for (int i = 0; i < 5; i++) begin
      step();
      if (e_rd_en || e_out_valid || e_done) bad++;
    end
    chk("empty_no_activity", bad, 0);

    words = 0;
    zero_hits = 0;
    seen_done = 1'b0;
    got0 = '0;
    got1 = '0;
    w_start = 1'b1;
    for (int i = 0; i < 30 && !seen_done; i++) begin
      step();
      w_start = 1'b0;
      if (w_rd_en && w_rd_index == 8'd0) zero_hits++;
      if (w_out_valid && w_out_ready) begin
        if (words == 0) got0 = w_out_index;
        if (words == 1) got1 = w_out_index;
        words++;
      end
      if (w_done) seen_done = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (w_rd_en && w_rd_index == 8'd0) zero_hits++;
      if (w_out_valid) words++;
    end
    chk("wrap_done_seen", seen_done, 1);
    chk("wrap_word_count", words, 2);
    chk("wrap_first_index", got0, 254);
    chk("wrap_second_index", got1, 255);
    chk("wrap_no_index0_read", zero_hits, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
